ps2_kbd_ascii_decoder: RTL and testbench
========================================

# ps2_kbd_ascii_decoder

Stateful PS/2 scan-code-set-2 to ASCII decoder with a parametrised output FIFO. It tracks make/break and extended prefixes, both shift keys and caps lock, and derives letter case internally. Decoded characters are buffered behind a valid/ready interface. It sits between the PS/2 receiver (byte strobe) and character consumers (UART/console/text buffer).

## Interface
- FIFO_DEPTH, 8, output FIFO entries; power of two, 2..64
- DROP_UNMAPPED, 1, 1: unmapped make codes are discarded; 0: they push DEFAULT_CHAR
- DEFAULT_CHAR, 8'h2A, character pushed for unmapped make codes when DROP_UNMAPPED=0
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- scan_valid  in  1  one-cycle strobe, scan_code valid
- scan_code  in  8  received PS/2 byte
- ascii_valid  out  1  FIFO non-empty; ascii_code valid
- ascii_code  out  8  FIFO head character
- ascii_ready  in  1  consumer pop; pop when ascii_valid && ascii_ready
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
- overflow  out  1  sticky: a character was dropped because FIFO full
- overflow_clr  in  1  synchronous clear of overflow
- shift_active  out  1  left or right shift currently held
- caps_lock  out  1  caps-lock toggle state

## Operation
- Prefix FSM, states IDLE, BREAK, EXT, EXT_BREAK; advances only on scan_valid.
  - 0xE0 in any state -> EXT. 0xF0: IDLE->BREAK, EXT->EXT_BREAK, BREAK/EXT_BREAK stay.
  - Any other byte is processed as a make (IDLE, EXT) or break (BREAK, EXT_BREAK) of that code, then FSM -> IDLE.
- In IDLE, bytes 0x00, 0xAA, 0xFA, 0xFE, 0xFF are ignored (no push, no state change).
- Modifiers (non-extended only): make 0x12 sets lshift, make 0x59 sets rshift; break clears each. shift_active = lshift|rshift. Extended 0x12/0x59 (fake shifts) ignored.
- Caps lock 0x58: make toggles caps_lock only if caps_held is clear, then sets caps_held; break clears caps_held (typematic repeats do not re-toggle).
- Break codes never push a character. Modifier and caps makes never push.
- Extended makes: only E0 4A -> '/' and E0 5A -> 0x0D push; all other extended codes ignored.
- Letters use upper case when shift_active XOR caps_lock; all other keys use shift_active only.
- Map (US layout; lower/upper): letters a 1C, b 32, c 21, d 23, e 24, f 2B, g 34, h 33, i 43, j 3B, k 42, l 4B, m 3A, n 31, o 44, p 4D, q 15, r 2D, s 1B, t 2C, u 3C, v 2A, w 1D, x 22, y 35, z 1A -> 0x61.. / 0x41..
- Digits 16,1E,26,25,2E,36,3D,3E,46,45 -> '1'..'9','0' / ! @ # $ % ^ & * ( ).
- Punctuation 0E `/~, 4E -/_, 55 =/+, 54 [/{, 5B ]/}, 5D \/|, 4C ;/:, 52 '/", 41 ,/<, 49 ./>, 4A //?.
- Shift-independent: 29 -> 0x20, 5A -> 0x0D, 66 -> 0x08, 0D -> 0x09.
- Other non-extended makes are unmapped and handled per DROP_UNMAPPED.
- FIFO: push when a character is generated. Full and no pop -> character dropped, overflow set. Full with simultaneous pop -> push accepted, count unchanged. Empty with push: no bypass.
- overflow: set has priority over overflow_clr in the same cycle.

## Timing
- Reset values: FSM IDLE, lshift/rshift/caps_held/caps_lock 0, FIFO empty, ascii_valid 0, ascii_code 0x00, fifo_count 0, overflow 0.
- Decode is registered. A scan_valid in cycle N produces a registered character in N+1, written at the end of N+1. ascii_valid rises in N+2 if the FIFO was empty.
- ascii_code/ascii_valid come straight from FIFO registers. After a pop at the end of cycle M, the next head is visible in M+1.
- Back-to-back scan_valid every cycle is supported at full rate.
- Modifier state updated by byte N applies to a character byte arriving in N+1 or later.
- Reset asserted mid-sequence (e.g. after 0xF0) discards the prefix and all FIFO contents immediately and asynchronously.

## Test plan
- Send 1C, F0 1C -> exactly one pop of 0x61; fifo_count returns to 0; no char from the break.
- Send 12, 1C, F0 12, 1C -> pops 0x41, 0x61; shift_active is 1 between make and break.
- Send 58, 58, F0 58 then 1C; then 12, 1C -> caps_lock=1 after single toggle; pops 0x41, then 0x61 (shift XOR caps). Send 12, 16 -> 0x21 (digits unaffected by caps).
- Send E0 12, E0 4A, E0 F0 4A, E0 75 -> shift_active stays 0; single pop 0x2F.
- With ascii_ready=0 and FIFO_DEPTH=8, send 10 'a' makes -> fifo_count=8, overflow=1. Pulse overflow_clr -> overflow=0. Pop all 8 -> 0x61 each.
- Send F0 then assert rst_n low mid-stream; after release, send 1C -> pop 0x61, not treated as a break. With DROP_UNMAPPED=0, send make 0x05 -> pops 0x2A.

Source files
------------

// File: rtl/ps2_kbd_ascii_decoder_if.sv
// Byte-strobe input and valid/ready character output of the PS/2 ASCII decoder.
interface ps2_kbd_ascii_decoder_if;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       ascii_valid;
  logic [7:0] ascii_code;
  logic       ascii_ready;

  modport master (
    input  scan_valid, scan_code, ascii_ready,
    output ascii_valid, ascii_code
  );

  modport slave (
    output scan_valid, scan_code, ascii_ready,
    input  ascii_valid, ascii_code
  );
endinterface

// File: rtl/ps2_kbd_ascii_decoder.sv
// PS/2 scan-code-set-2 to ASCII decoder: prefix FSM, shift/caps tracking,
// registered decode and an output FIFO behind a valid/ready handshake.
module ps2_kbd_ascii_decoder #(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter bit          DROP_UNMAPPED = 1'b1,
  parameter logic [7:0]  DEFAULT_CHAR  = 8'h2A
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ps2_kbd_ascii_decoder_if.master       kbd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          shift_active,
  output logic                          caps_lock
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_e;

  state_e        state_q, state_d;
  logic          lshift_q, lshift_d, rshift_q, rshift_d;
  logic          caps_held_q, caps_held_d, caps_lock_q, caps_lock_d;
  logic          char_vld_q, char_vld_d;
  logic [7:0]    char_q, char_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          is_ext, is_brk, is_prefix, ignored;
  logic          map_hit, map_letter, upper;
  logic [7:0]    map_lo, map_hi;
  logic          pop, full, push;

  assign is_ext    = (state_q == EXT) || (state_q == EXT_BREAK);
  assign is_brk    = (state_q == BREAK) || (state_q == EXT_BREAK);
  assign is_prefix = (kbd.scan_code == 8'hE0) || (kbd.scan_code == 8'hF0);
  assign ignored   = kbd.scan_code inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF};

  // Letters only set map_lo; their upper case is derived below.
  always_comb begin
    map_hit = 1'b1;
    map_lo  = '0;
    map_hi  = '0;
    case (kbd.scan_code)
      8'h1C: map_lo = 8'h61;  8'h32: map_lo = 8'h62;  8'h21: map_lo = 8'h63;
      8'h23: map_lo = 8'h64;  8'h24: map_lo = 8'h65;  8'h2B: map_lo = 8'h66;
      8'h34: map_lo = 8'h67;  8'h33: map_lo = 8'h68;  8'h43: map_lo = 8'h69;
      8'h3B: map_lo = 8'h6A;  8'h42: map_lo = 8'h6B;  8'h4B: map_lo = 8'h6C;
      8'h3A: map_lo = 8'h6D;  8'h31: map_lo = 8'h6E;  8'h44: map_lo = 8'h6F;
      8'h4D: map_lo = 8'h70;  8'h15: map_lo = 8'h71;  8'h2D: map_lo = 8'h72;
      8'h1B: map_lo = 8'h73;  8'h2C: map_lo = 8'h74;  8'h3C: map_lo = 8'h75;
      8'h2A: map_lo = 8'h76;  8'h1D: map_lo = 8'h77;  8'h22: map_lo = 8'h78;
      8'h35: map_lo = 8'h79;  8'h1A: map_lo = 8'h7A;
      8'h16: begin map_lo = 8'h31; map_hi = 8'h21; end
      8'h1E: begin map_lo = 8'h32; map_hi = 8'h40; end
      8'h26: begin map_lo = 8'h33; map_hi = 8'h23; end
      8'h25: begin map_lo = 8'h34; map_hi = 8'h24; end
      8'h2E: begin map_lo = 8'h35; map_hi = 8'h25; end
      8'h36: begin map_lo = 8'h36; map_hi = 8'h5E; end
      8'h3D: begin map_lo = 8'h37; map_hi = 8'h26; end
      8'h3E: begin map_lo = 8'h38; map_hi = 8'h2A; end
      8'h46: begin map_lo = 8'h39; map_hi = 8'h28; end
      8'h45: begin map_lo = 8'h30; map_hi = 8'h29; end
      8'h0E: begin map_lo = 8'h60; map_hi = 8'h7E; end
      8'h4E: begin map_lo = 8'h2D; map_hi = 8'h5F; end
      8'h55: begin map_lo = 8'h3D; map_hi = 8'h2B; end
      8'h54: begin map_lo = 8'h5B; map_hi = 8'h7B; end
      8'h5B: begin map_lo = 8'h5D; map_hi = 8'h7D; end
      8'h5D: begin map_lo = 8'h5C; map_hi = 8'h7C; end
      8'h4C: begin map_lo = 8'h3B; map_hi = 8'h3A; end
      8'h52: begin map_lo = 8'h27; map_hi = 8'h22; end
      8'h41: begin map_lo = 8'h2C; map_hi = 8'h3C; end
      8'h49: begin map_lo = 8'h2E; map_hi = 8'h3E; end
      8'h4A: begin map_lo = 8'h2F; map_hi = 8'h3F; end
      8'h29: begin map_lo = 8'h20; map_hi = 8'h20; end
      8'h5A: begin map_lo = 8'h0D; map_hi = 8'h0D; end
      8'h66: begin map_lo = 8'h08; map_hi = 8'h08; end
      8'h0D: begin map_lo = 8'h09; map_hi = 8'h09; end
      default: map_hit = 1'b0;
    endcase
    map_letter = map_lo inside {[8'h61:8'h7A]};
    if (map_letter) map_hi = map_lo ^ 8'h20;
  end

  assign upper = map_letter ? (shift_active ^ caps_lock_q) : shift_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kbd.scan_valid) begin
      if (kbd.scan_code == 8'hE0)      state_d = EXT;
      else if (kbd.scan_code == 8'hF0) state_d = is_ext ? EXT_BREAK : BREAK;
      else                             state_d = IDLE;
    end
  end

  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_held_d = caps_held_q;
    caps_lock_d = caps_lock_q;
    char_vld_d  = 1'b0;
    char_d      = char_q;
    if (kbd.scan_valid && !is_prefix && !(state_q == IDLE && ignored)) begin
      if (!is_ext) begin
        case (kbd.scan_code)
          8'h12: lshift_d = !is_brk;
          8'h59: rshift_d = !is_brk;
          8'h58: begin
            if (!is_brk && !caps_held_q) caps_lock_d = !caps_lock_q;
            caps_held_d = !is_brk;
          end
          default: begin
            if (!is_brk && map_hit) begin
              char_vld_d = 1'b1;
              char_d     = upper ? map_hi : map_lo;
            end else if (!is_brk && !DROP_UNMAPPED) begin
              char_vld_d = 1'b1;
              char_d     = DEFAULT_CHAR;
            end
          end
        endcase
      end else if (!is_brk && (kbd.scan_code == 8'h4A || kbd.scan_code == 8'h5A)) begin
        char_vld_d = 1'b1;
        char_d     = map_lo;
      end
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    pop        = (count_q != '0) && kbd.ascii_ready;
    full       = (count_q == (AW+1)'(FIFO_DEPTH));
    push       = char_vld_q && (!full || pop);
    mem_d      = mem_q;
    if (push) mem_d[wr_ptr_q] = char_q;
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    overflow_d = (char_vld_q && full && !pop) || (overflow_q && !overflow_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_held_q <= 1'b0;
      caps_lock_q <= 1'b0;
      char_vld_q  <= 1'b0;
      char_q      <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_held_q <= caps_held_d;
      caps_lock_q <= caps_lock_d;
      char_vld_q  <= char_vld_d;
      char_q      <= char_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  assign kbd.ascii_valid = (count_q != '0);
  assign kbd.ascii_code  = mem_q[rd_ptr_q];
  assign fifo_count      = count_q;
  assign overflow        = overflow_q;
  assign shift_active    = lshift_q || rshift_q;
  assign caps_lock       = caps_lock_q;
endmodule

// File: tb/tb_ps2_kbd_ascii_decoder.sv
// Bench for ps2_kbd_ascii_decoder: a dropping and a default-char instance share
// one byte stream and are compared every cycle against a keyboard-level model.
module tb_ps2_kbd_ascii_decoder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       s_valid, s_ready, clr;
  logic [7:0] s_code;
  logic [3:0] cnt0, cnt1;
  logic       ovf0, ovf1, sh0, sh1, cl0, cl1;

  ps2_kbd_ascii_decoder_if if0 ();
  ps2_kbd_ascii_decoder_if if1 ();
  assign if0.scan_valid  = s_valid;
  assign if0.scan_code   = s_code;
  assign if0.ascii_ready = s_ready;
  assign if1.scan_valid  = s_valid;
  assign if1.scan_code   = s_code;
  assign if1.ascii_ready = s_ready;

  ps2_kbd_ascii_decoder #(.FIFO_DEPTH(8), .DROP_UNMAPPED(1'b1), .DEFAULT_CHAR(8'h2A)) dut0 (
    .clk(clk), .rst_n(rst_n), .kbd(if0), .fifo_count(cnt0), .overflow(ovf0),
    .overflow_clr(clr), .shift_active(sh0), .caps_lock(cl0));
  ps2_kbd_ascii_decoder #(.FIFO_DEPTH(8), .DROP_UNMAPPED(1'b0), .DEFAULT_CHAR(8'h2A)) dut1 (
    .clk(clk), .rst_n(rst_n), .kbd(if1), .fifo_count(cnt1), .overflow(ovf1),
    .overflow_clr(clr), .shift_active(sh1), .caps_lock(cl1));

  // Key tables: letter i is 'a'+i; other keys carry explicit unshifted/shifted chars.
  logic [7:0] letter_code [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A,
    8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] other_code [25] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h45, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h29,
    8'h5A, 8'h66, 8'h0D};
  logic [7:0] other_lo [25] = '{"1", "2", "3", "4", "5", "6", "7", "8", "9", "0", 8'h60, "-", "=",
    "[", "]", "\\", ";", "'", ",", ".", "/", 8'h20, 8'h0D, 8'h08, 8'h09};
  logic [7:0] other_hi [25] = '{"!", "@", "#", "$", "%", "^", "&", "*", "(", ")", "~", "_", "+",
    "{", "}", "|", ":", "\"", "<", ">", "?", 8'h20, 8'h0D, 8'h08, 8'h09};

  logic [7:0] mq [2][$];
  bit         pend_v [2];
  logic [7:0] pend_c [2];
  bit         m_ovf [2];
  bit         m_ext, m_brk, m_lsh, m_rsh, m_caps, m_held;
  int         n_cmp = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void lookup(input logic [7:0] c, input bit up_letter, input bit up_other,
                                 output bit hit, output logic [7:0] ch);
    hit = 1'b0;
    ch  = 8'h00;
    for (int i = 0; i < 26; i++)
      if (letter_code[i] == c) begin hit = 1'b1; ch = (up_letter ? 8'h41 : 8'h61) + 8'(i); end
    for (int i = 0; i < 25; i++)
      if (other_code[i] == c) begin hit = 1'b1; ch = up_other ? other_hi[i] : other_lo[i]; end
  endfunction

  task automatic emit(input int k, input logic [7:0] ch);
    pend_v[k] = 1'b1;
    pend_c[k] = ch;
  endtask

  task automatic key_event(input logic [7:0] c, input bit ext, input bit brk);
    bit shifted, hit;
    logic [7:0] ch;
    shifted = m_lsh || m_rsh;
    if (ext) begin
      if (!brk && c == 8'h4A) begin emit(0, "/"); emit(1, "/"); end
      if (!brk && c == 8'h5A) begin emit(0, 8'h0D); emit(1, 8'h0D); end
    end else if (c == 8'h12) m_lsh = !brk;
    else if (c == 8'h59) m_rsh = !brk;
    else if (c == 8'h58) begin
      if (brk) m_held = 1'b0;
      else begin
        if (!m_held) m_caps = !m_caps;
        m_held = 1'b1;
      end
    end else if (!brk) begin
      lookup(c, shifted ^ m_caps, shifted, hit, ch);
      if (hit) begin emit(0, ch); emit(1, ch); end
      else emit(1, 8'h2A);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      pend_v[k] = 1'b0;
      m_ovf[k]  = 1'b0;
    end
    {m_ext, m_brk, m_lsh, m_rsh, m_caps, m_held} = '0;
  endtask

  // One clock edge: the previous byte's character enters the FIFO, this byte is decoded.
  task automatic model_edge(input logic v, input logic [7:0] c, input logic r, input logic cl);
    for (int k = 0; k < 2; k++) begin
      bit pop, full, set;
      pop  = (mq[k].size() != 0) && r;
      full = (mq[k].size() == 8);
      set  = 1'b0;
      if (pop) void'(mq[k].pop_front());
      if (pend_v[k]) begin
        if (full && !pop) set = 1'b1;
        else mq[k].push_back(pend_c[k]);
      end
      m_ovf[k]  = set || (m_ovf[k] && !cl);
      pend_v[k] = 1'b0;
    end
    if (v) begin
      if (c == 8'hE0) begin m_ext = 1'b1; m_brk = 1'b0; end
      else if (c == 8'hF0) m_brk = 1'b1;
      else if (!m_ext && !m_brk && (c inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF})) begin end
      else begin
        key_event(c, m_ext, m_brk);
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("valid0", 32'(if0.ascii_valid), 32'(mq[0].size() != 0));
    chk("valid1", 32'(if1.ascii_valid), 32'(mq[1].size() != 0));
    if (mq[0].size() != 0) chk("head0", 32'(if0.ascii_code), 32'(mq[0][0]));
    if (mq[1].size() != 0) chk("head1", 32'(if1.ascii_code), 32'(mq[1][0]));
    chk("count0", 32'(cnt0), 32'(mq[0].size()));
    chk("count1", 32'(cnt1), 32'(mq[1].size()));
    chk("ovf0", 32'(ovf0), 32'(m_ovf[0]));
    chk("ovf1", 32'(ovf1), 32'(m_ovf[1]));
    chk("shift", 32'(sh0), 32'(m_lsh || m_rsh));
    chk("caps", 32'(cl0), 32'(m_caps));
    chk("shift1", 32'(sh1), 32'(m_lsh || m_rsh));
    chk("caps1", 32'(cl1), 32'(m_caps));
  endtask

  task automatic step(input logic v, input logic [7:0] c, input logic r, input logic cl);
    s_valid = v;
    s_code  = c;
    s_ready = r;
    clr     = cl;
    @(posedge clk);
    model_edge(v, c, r, cl);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, r, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(if0.ascii_valid), 32'h0);
    chk({tag, "_code"}, 32'(if0.ascii_code), 32'h0);
    chk({tag, "_count"}, 32'(cnt0), 32'h0);
    chk({tag, "_ovf"}, 32'(ovf0), 32'h0);
    chk({tag, "_shift"}, 32'(sh0), 32'h0);
    chk({tag, "_caps"}, 32'(cl0), 32'h0);
    chk({tag, "_count1"}, 32'(cnt1), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_code = 8'h00; s_ready = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // make then break of 'a': latency of two edges, one character only
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    chk("a_lat1", 32'(if0.ascii_valid), 32'h0);
    idle(1, 1'b0);
    chk("a_lat2", 32'(if0.ascii_valid), 32'h1);
    chk("a_head", 32'(if0.ascii_code), 32'h61);
    step(1'b1, 8'hF0, 1'b1, 1'b0);
    step(1'b1, 8'h1C, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("a_drain", 32'(cnt0), 32'h0);

    // shift held around a letter
    step(1'b1, 8'h12, 1'b1, 1'b0);
    chk("sh_on", 32'(sh0), 32'h1);
    step(1'b1, 8'h1C, 1'b1, 1'b0);
    step(1'b1, 8'hF0, 1'b1, 1'b0);
    step(1'b1, 8'h12, 1'b1, 1'b0);
    chk("sh_off", 32'(sh0), 32'h0);
    step(1'b1, 8'h1C, 1'b1, 1'b0);
    idle(3, 1'b1);

    // caps lock with typematic repeat, then shift XOR caps, digits ignore caps
    step(1'b1, 8'h58, 1'b0, 1'b0);
    step(1'b1, 8'h58, 1'b0, 1'b0);
    step(1'b1, 8'hF0, 1'b0, 1'b0);
    step(1'b1, 8'h58, 1'b0, 1'b0);
    chk("caps_on", 32'(cl0), 32'h1);
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    step(1'b1, 8'h12, 1'b0, 1'b0);
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    step(1'b1, 8'h12, 1'b0, 1'b0);
    step(1'b1, 8'h16, 1'b0, 1'b0);
    step(1'b1, 8'hF0, 1'b0, 1'b0);
    step(1'b1, 8'h12, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("caps_cnt", 32'(cnt0), 32'h3);
    chk("caps_A", 32'(if0.ascii_code), 32'h41);
    idle(1, 1'b1);
    chk("caps_a", 32'(if0.ascii_code), 32'h61);
    idle(1, 1'b1);
    chk("caps_bang", 32'(if0.ascii_code), 32'h21);
    idle(1, 1'b1);
    step(1'b1, 8'h58, 1'b1, 1'b0);
    step(1'b1, 8'hF0, 1'b1, 1'b0);
    step(1'b1, 8'h58, 1'b1, 1'b0);
    chk("caps_off", 32'(cl0), 32'h0);

    // extended codes: fake shift ignored, keypad slash pushed once
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    step(1'b1, 8'h12, 1'b0, 1'b0);
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    step(1'b1, 8'h4A, 1'b0, 1'b0);
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    step(1'b1, 8'hF0, 1'b0, 1'b0);
    step(1'b1, 8'h4A, 1'b0, 1'b0);
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    step(1'b1, 8'h75, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("ext_shift", 32'(sh0), 32'h0);
    chk("ext_cnt", 32'(cnt0), 32'h1);
    chk("ext_slash", 32'(if0.ascii_code), 32'h2F);
    idle(2, 1'b1);

    // overflow with ready low, sticky until cleared, then drain
    for (int i = 0; i < 10; i++) step(1'b1, 8'h1C, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("full_cnt", 32'(cnt0), 32'h8);
    chk("full_ovf", 32'(ovf0), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(ovf0), 32'h0);
    idle(9, 1'b1);
    chk("drained", 32'(cnt0), 32'h0);

    // asynchronous reset after a break prefix, with FIFO contents and caps set
    step(1'b1, 8'h58, 1'b0, 1'b0);
    step(1'b1, 8'hF0, 1'b0, 1'b0);
    step(1'b1, 8'h58, 1'b0, 1'b0);
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    step(1'b1, 8'hF0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("post_rst_a", 32'(if0.ascii_code), 32'h61);
    idle(1, 1'b1);

    // unmapped make: dropped by one instance, default char from the other
    step(1'b1, 8'h05, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("unm_cnt0", 32'(cnt0), 32'h0);
    chk("unm_char1", 32'(if1.ascii_code), 32'h2A);
    idle(2, 1'b1);

    // randomized byte stream
    for (int n = 0; n < 800; n++) begin
      logic [7:0] c;
      logic v, r, cl;
      case ($urandom_range(0, 9))
        0, 1, 2: c = letter_code[$urandom_range(0, 25)];
        3, 4:    c = other_code[$urandom_range(0, 24)];
        5:       c = ($urandom_range(0, 1) != 0) ? 8'hE0 : 8'hF0;
        6: begin
          case ($urandom_range(0, 2))
            0: c = 8'h12;
            1: c = 8'h59;
            default: c = 8'h58;
          endcase
        end
        7: begin
          case ($urandom_range(0, 4))
            0: c = 8'h00;
            1: c = 8'hAA;
            2: c = 8'hFF;
            3: c = 8'h05;
            default: c = 8'h76;
          endcase
        end
        default: c = 8'($urandom_range(0, 255));
      endcase
      v  = ($urandom_range(0, 3) != 0);
      r  = (n < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      cl = ($urandom_range(0, 15) == 0);
      step(v, c, r, cl);
    end
    idle(12, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
